// File: rtl/fp_pkg.sv
// Shared fp32 definitions: field widths, bias, converter FSM states and
// 32-bit saturation constants (narrower integer widths shift these down).
package fp_pkg;

    localparam int unsigned FP32_EXP_W  = 8;
    localparam int unsigned FP32_FRAC_W = 23;
    localparam int unsigned FP32_MANT_W = FP32_FRAC_W + 1;
    localparam int unsigned FP32_BIAS   = 127;
    localparam logic [FP32_EXP_W-1:0] FP32_EXP_MAX = 8'hFF;

    // Alignment shift counter width; the longest shift is 23 positions.
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_OUT   = 2'd2
    } cvt_state_e;

    localparam logic [31:0] SAT_S_MAX_32 = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_S_MIN_32 = 32'h8000_0000;
    localparam logic [31:0] SAT_U_MAX_32 = 32'hFFFF_FFFF;
    localparam logic [31:0] SAT_U_NEG_32 = 32'h0000_0000;

    typedef struct packed {
        logic                   sign;
        logic [FP32_EXP_W-1:0]  exp;
        logic [FP32_FRAC_W-1:0] frac;
    } fp32_t;

    // Unbiased exponent as signed 9-bit: -127 .. 128.
    function automatic logic signed [8:0] unbiased_exp(input logic [FP32_EXP_W-1:0] exp);
        return $signed({1'b0, exp}) - 9'sd127;
    endfunction

endpackage

// File: rtl/fp32_unpack.sv
// Combinational fp32 field decoder, shared with the FP add/sub unit.
// Ports: i_operand (fp32) -> o_sign, o_exp, o_mant (hidden bit included),
//        o_is_zero, o_is_denorm, o_is_inf, o_is_nan.
module fp32_unpack
    import fp_pkg::*;
(
    input  logic [31:0]              i_operand,
    output logic                     o_sign,
    output logic [FP32_EXP_W-1:0]    o_exp,
    output logic [FP32_MANT_W-1:0]   o_mant,
    output logic                     o_is_zero,
    output logic                     o_is_denorm,
    output logic                     o_is_inf,
    output logic                     o_is_nan
);

    fp32_t w_fp;
    logic  w_exp_zero;
    logic  w_exp_max;
    logic  w_frac_zero;

    assign w_fp        = fp32_t'(i_operand);
    assign w_exp_zero  = (w_fp.exp == '0);
    assign w_exp_max   = (w_fp.exp == FP32_EXP_MAX);
    assign w_frac_zero = (w_fp.frac == '0);

    assign o_sign      = w_fp.sign;
    assign o_exp       = w_fp.exp;
    // Hidden bit is 1 for every nonzero exponent field.
    assign o_mant      = {~w_exp_zero, w_fp.frac};
    assign o_is_zero   = w_exp_zero & w_frac_zero;
    assign o_is_denorm = w_exp_zero & ~w_frac_zero;
    assign o_is_inf    = w_exp_max & w_frac_zero;
    assign o_is_nan    = w_exp_max & ~w_frac_zero;

endmodule

// File: rtl/fp32_to_int_converter.sv
// fp32 -> INT_W-bit integer converter, round toward zero, iterative alignment
// (one bit per cycle). Special/out-of-range operands bypass alignment.
// Ports: i_clk, i_rst_n (async, active-low); input handshake i_valid/o_ready
//        with i_operand and i_signed; output handshake o_valid/i_ready with
//        o_result and flags o_overflow, o_invalid, o_inexact.
module fp32_to_int_converter
    import fp_pkg::*;
#(
    parameter int unsigned INT_W = 32
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_operand,
    input  logic             i_signed,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [INT_W-1:0] o_result,
    output logic             o_overflow,
    output logic             o_invalid,
    output logic             o_inexact
);

    localparam logic [INT_W-1:0] SAT_S_MAX = INT_W'(SAT_S_MAX_32 >> (32 - INT_W));
    localparam logic [INT_W-1:0] SAT_S_MIN = INT_W'(SAT_S_MIN_32 >> (32 - INT_W));
    localparam logic [INT_W-1:0] SAT_U_MAX = INT_W'(SAT_U_MAX_32 >> (32 - INT_W));
    localparam logic [INT_W-1:0] SAT_U_NEG = INT_W'(SAT_U_NEG_32);

    // Largest in-range unbiased exponent for signed / first out-of-range for unsigned.
    localparam logic signed [8:0] E_SMAX  = 9'(INT_W - 1);
    localparam logic signed [8:0] E_UMAX  = 9'(INT_W);
    // Exponent at which the 24-bit mantissa is already an integer.
    localparam logic signed [8:0] E_ALIGN = 9'sd23;

    cvt_state_e r_state;
    logic                   r_sign;
    logic                   r_signed;
    logic [INT_W-1:0]       r_mag;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_dir_left;
    logic                   r_sticky;

    logic                   w_sign;
    logic [FP32_EXP_W-1:0]  w_exp;
    logic [FP32_MANT_W-1:0] w_mant;
    logic                   w_is_zero;
    logic                   w_is_denorm;
    logic                   w_is_inf;
    logic                   w_is_nan;

    logic signed [8:0]      w_e;
    logic signed [8:0]      w_e_m23;
    logic [CNT_W-1:0]       w_cnt;
    logic [INT_W-1:0]       w_sat;

    logic                   w_fast;
    logic [INT_W-1:0]       w_fast_res;
    logic                   w_fast_ovf;
    logic                   w_fast_inv;
    logic                   w_fast_inx;

    fp32_unpack u_unpack (
        .i_operand   (i_operand),
        .o_sign      (w_sign),
        .o_exp       (w_exp),
        .o_mant      (w_mant),
        .o_is_zero   (w_is_zero),
        .o_is_denorm (w_is_denorm),
        .o_is_inf    (w_is_inf),
        .o_is_nan    (w_is_nan)
    );

    assign o_ready = (r_state == ST_IDLE);

    // Shift distance and direction needed to place the binary point at bit 0.
    assign w_e     = unbiased_exp(w_exp);
    assign w_e_m23 = w_e - E_ALIGN;
    assign w_cnt   = w_e_m23[8] ? CNT_W'(-w_e_m23) : CNT_W'(w_e_m23);

    assign w_sat = i_signed ? (w_sign ? SAT_S_MIN : SAT_S_MAX)
                            : (w_sign ? SAT_U_NEG : SAT_U_MAX);

    // Operands whose result is known without alignment.
    always_comb begin
        w_fast     = 1'b1;
        w_fast_res = '0;
        w_fast_ovf = 1'b0;
        w_fast_inv = 1'b0;
        w_fast_inx = 1'b0;
        if (w_is_nan) begin
            w_fast_inv = 1'b1;
        end else if (w_is_inf) begin
            w_fast_inv = 1'b1;
            w_fast_res = w_sat;
        end else if (w_is_zero || w_is_denorm || w_e[8]) begin
            // Magnitude below one: truncates to zero.
            w_fast_inx = |{w_exp, w_mant[FP32_FRAC_W-1:0]};
        end else if (i_signed) begin
            if (w_e > E_SMAX) begin
                w_fast_ovf = 1'b1;
                w_fast_res = w_sat;
            end else if (w_e == E_SMAX) begin
                // Only -2^(INT_W-1) exactly is representable at this exponent.
                if (w_sign && (w_mant[FP32_FRAC_W-1:0] == '0)) begin
                    w_fast_res = SAT_S_MIN;
                end else begin
                    w_fast_ovf = 1'b1;
                    w_fast_res = w_sat;
                end
            end else begin
                w_fast = 1'b0;
            end
        end else begin
            if (w_e >= E_UMAX) begin
                w_fast_ovf = 1'b1;
                w_fast_res = w_sat;
            end else if (w_sign) begin
                w_fast_ovf = 1'b1;
                w_fast_res = SAT_U_NEG;
            end else begin
                w_fast = 1'b0;
            end
        end
    end

    // Control FSM with alignment datapath and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_sign     <= 1'b0;
            r_signed   <= 1'b0;
            r_mag      <= '0;
            r_cnt      <= '0;
            r_dir_left <= 1'b0;
            r_sticky   <= 1'b0;
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_overflow <= 1'b0;
            o_invalid  <= 1'b0;
            o_inexact  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_sign     <= w_sign;
                        r_signed   <= i_signed;
                        r_mag      <= INT_W'(w_mant);
                        r_cnt      <= w_cnt;
                        r_dir_left <= ~w_e_m23[8];
                        r_sticky   <= 1'b0;
                        if (w_fast) begin
                            o_result   <= w_fast_res;
                            o_overflow <= w_fast_ovf;
                            o_invalid  <= w_fast_inv;
                            o_inexact  <= w_fast_inx;
                            o_valid    <= 1'b1;
                            r_state    <= ST_OUT;
                        end else begin
                            r_state    <= ST_ALIGN;
                        end
                    end
                end
                ST_ALIGN: begin
                    if (r_cnt != '0) begin
                        if (r_dir_left) begin
                            r_mag <= r_mag << 1;
                        end else begin
                            r_mag    <= r_mag >> 1;
                            r_sticky <= r_sticky | r_mag[0];
                        end
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        o_result   <= (r_sign & r_signed) ? -r_mag : r_mag;
                        o_overflow <= 1'b0;
                        o_invalid  <= 1'b0;
                        o_inexact  <= r_sticky;
                        o_valid    <= 1'b1;
                        r_state    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
